// File: rtl/multisim_apb_arbiter.sv
// Round-robin arbiter that lets NUM_REQ upstream APB requesters share one downstream APB manager path.
// Only one transfer is in flight at a time. The granted payload is registered so that it stays stable downstream.
module multisim_apb_arbiter #(
    parameter int  NUM_REQ    = 2,
    parameter type apb_req_t  = logic,
    parameter type apb_resp_t = logic,
    localparam int IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  apb_req_t           i_apb_s_req     [NUM_REQ],
    input  logic [NUM_REQ-1:0] i_apb_s_psel,
    input  logic [NUM_REQ-1:0] i_apb_s_penable,
    output logic [NUM_REQ-1:0] o_apb_s_pready,
    output apb_resp_t          o_apb_s_resp    [NUM_REQ],
    output apb_req_t           o_apb_m_req,
    output logic               o_apb_m_psel,
    output logic               o_apb_m_penable,
    input  logic               i_apb_m_pready,
    input  apb_resp_t          i_apb_m_resp,
    output logic               o_grant_vld,
    output logic [IW-1:0]      o_grant_idx
);

    localparam int SW = IW + 1;
    localparam int PW = 2 ** IW;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] winner;
    logic          any_req;
    logic [PW-1:0] psel_ext;

    // Arbitration ignores the upstream penable. A requester in its own ACCESS phase just waits.
    logic unused_penable;
    assign unused_penable = ^i_apb_s_penable;

    // Pad psel to a power of two so that every IW-bit candidate index is in range.
    assign psel_ext = PW'(i_apb_s_psel);

    // Search for the first asserted psel, starting at rr_ptr and wrapping modulo NUM_REQ.
    // NOTE: every variable in this block gets a value before it is tested; otherwise a latch is inferred.
    always_comb begin
        logic [SW-1:0] sum;
        winner  = '0;
        any_req = 1'b0;
        sum     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + SW'(k);
            if (sum >= SW'(NUM_REQ)) begin
                sum = sum - SW'(NUM_REQ);
            end
            if (!any_req && psel_ext[sum[IW-1:0]]) begin
                any_req = 1'b1;
                winner  = sum[IW-1:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            o_grant_idx     <= '0;
            o_grant_vld     <= 1'b0;
            o_apb_m_req     <= '0;
            o_apb_m_psel    <= 1'b0;
            o_apb_m_penable <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        state        <= SETUP;
                        o_grant_idx  <= winner;
                        o_apb_m_req  <= i_apb_s_req[winner];
                        o_apb_m_psel <= 1'b1;
                        o_grant_vld  <= 1'b1;
                    end
                end
                SETUP: begin
                    state           <= ACCESS;
                    o_apb_m_penable <= 1'b1;
                end
                ACCESS: begin
                    // The downstream transfer always completes, even if the requester has since dropped psel.
                    if (i_apb_m_pready) begin
                        state           <= IDLE;
                        o_apb_m_psel    <= 1'b0;
                        o_apb_m_penable <= 1'b0;
                        o_grant_vld     <= 1'b0;
                        if (o_grant_idx == IW'(NUM_REQ - 1)) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= o_grant_idx + IW'(1);
                        end
                    end
                end
                default: begin
                    state           <= IDLE;
                    o_apb_m_psel    <= 1'b0;
                    o_apb_m_penable <= 1'b0;
                    o_grant_vld     <= 1'b0;
                end
            endcase
        end
    end

    // Only the granted port sees the downstream response, and only while in ACCESS.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            o_apb_s_pready[i] = 1'b0;
            o_apb_s_resp[i]   = '0;
            if (state == ACCESS && o_grant_idx == IW'(i)) begin
                o_apb_s_pready[i] = i_apb_m_pready;
                o_apb_s_resp[i]   = i_apb_m_resp;
            end
        end
    end

endmodule

// File: tb/tb_multisim_apb_arbiter.sv
// Scoreboard bench for multisim_apb_arbiter (NUM_REQ=4): expected grants are queued at stimulus time
// and compared when the downstream transfer completes.
module tb_multisim_apb_arbiter;

    localparam int N = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        slverr;
    } resp_t;

    typedef struct {
        int    idx;
        req_t  req;
        resp_t resp;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    req_t           s_req     [N];
    logic [N-1:0]   s_psel;
    logic [N-1:0]   s_penable;
    logic [N-1:0]   s_pready;
    resp_t          s_resp    [N];
    req_t           m_req;
    logic           m_psel;
    logic           m_penable;
    logic           m_pready;
    resp_t          m_resp;
    logic           grant_vld;
    logic [1:0]     grant_idx;

    int    n_vec = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    last_done = -1;
    bit    chk_gap = 1'b0;
    int    ws = 0;
    resp_t resp_val = '0;
    int    seq       [N];
    int    remaining [N];
    exp_t  sb [$];

    multisim_apb_arbiter #(
        .NUM_REQ    (N),
        .apb_req_t  (req_t),
        .apb_resp_t (resp_t)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_apb_s_req     (s_req),
        .i_apb_s_psel    (s_psel),
        .i_apb_s_penable (s_penable),
        .o_apb_s_pready  (s_pready),
        .o_apb_s_resp    (s_resp),
        .o_apb_m_req     (m_req),
        .o_apb_m_psel    (m_psel),
        .o_apb_m_penable (m_penable),
        .i_apb_m_pready  (m_pready),
        .i_apb_m_resp    (m_resp),
        .o_grant_vld     (grant_vld),
        .o_grant_idx     (grant_idx)
    );

    always #5 clk = ~clk;

    // Downstream subordinate: it raises pready after ws wait cycles in ACCESS and returns resp_val only with pready.
    initial begin
        int acc;
        acc      = 0;
        m_pready = 1'b0;
        m_resp   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !(m_psel && m_penable)) begin
                acc      = 0;
                m_pready = 1'b0;
            end else begin
                m_pready = (acc == ws);
                acc++;
            end
            m_resp = m_pready ? resp_val : '0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic req_t mk_req(input int port, input int n);
        req_t r;
        r.addr  = 32'(port * 32'h1000 + n * 4);
        r.write = n[0];
        r.wdata = 32'(32'hA500_0000 + port * 256 + n);
        r.strb  = 4'hF;
        return r;
    endfunction

    task automatic push(input int idx, input req_t r, input resp_t rs);
        exp_t e;
        e.idx  = idx;
        e.req  = r;
        e.resp = rs;
        sb.push_back(e);
    endtask

    task automatic start_req(input int idx, input int count);
        remaining[idx] = count;
        s_req[idx]     = mk_req(idx, seq[idx]);
        s_psel[idx]    = 1'b1;
    endtask

    // Advance one cycle, sample at the falling edge, score completions and step the requester agents.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (chk_gap && m_psel && !m_penable && last_done >= 0) begin
            check("idle_gap", 128'(cyc - last_done), 128'd2);
        end
        if (m_psel && m_penable && m_pready) begin
            if (sb.size() == 0) begin
                check("unexpected_grant", {grant_vld, grant_idx}, 128'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("grant_idx", grant_idx, 128'(e.idx));
                check("m_req", m_req, e.req);
                check("s_pready", s_pready, 128'(1 << e.idx));
                check("s_resp", s_resp[e.idx], e.resp);
            end
            last_done = cyc;
        end
        for (int i = 0; i < N; i++) begin
            if (s_psel[i] && s_pready[i]) begin
                seq[i]++;
                s_penable[i] = 1'b0;
                if (remaining[i] > 0) remaining[i]--;
                if (remaining[i] == 0) s_psel[i] = 1'b0;
                else s_req[i] = mk_req(i, seq[i]);
            end else begin
                s_penable[i] = s_psel[i];
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || grant_vld) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_done", 128'(sb.size()), 128'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_psel"}, {m_psel, m_penable, grant_vld}, 128'd0);
        check({tag, "_idx"}, grant_idx, 128'd0);
        check({tag, "_mreq"}, m_req, 128'd0);
        check({tag, "_pready"}, s_pready, 128'd0);
        for (int i = 0; i < N; i++) check({tag, "_resp"}, s_resp[i], 128'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        req_t r;
        rst       = 1'b1;
        s_psel    = '0;
        s_penable = '0;
        for (int i = 0; i < N; i++) begin
            s_req[i]     = '0;
            seq[i]       = 0;
            remaining[i] = 0;
        end
        repeat (2) @(negedge clk);
        check_reset("rst");
        rst = 1'b0;
        cycle();
        check_reset("post_rst");

        // Single zero-wait write from port 0
        ws = 0;
        resp_val = '{rdata: 32'h0, slverr: 1'b0};
        r = mk_req(0, seq[0]);
        r.addr = 32'h10;
        r.write = 1'b1;
        push(0, r, resp_val);
        s_req[0] = r;
        s_psel[0] = 1'b1;
        remaining[0] = 1;
        cycle();
        check("single_setup", {m_psel, m_penable}, 128'b10);
        check("single_grant", {grant_vld, grant_idx}, 128'b100);
        check("single_setup_pready", s_pready, 128'd0);
        cycle();
        check("single_access", {m_psel, m_penable}, 128'b11);
        check("single_pready", s_pready, 128'b0001);
        check("single_mreq", m_req, r);
        cycle();
        check("single_idle", {grant_vld, m_psel}, 128'd0);

        // Four wait states with read data returned
        ws = 4;
        resp_val = '{rdata: 32'hDEADBEEF, slverr: 1'b0};
        r = mk_req(0, seq[0]);
        r.write = 1'b0;
        push(0, r, resp_val);
        s_req[0] = r;
        s_psel[0] = 1'b1;
        remaining[0] = 1;
        cycle();
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("ws_penable", {m_psel, m_penable}, 128'b11);
            check("ws_pready", s_pready, 128'd0);
            check("ws_rdata_hold", s_resp[0], 128'd0);
            check("ws_mreq", m_req, r);
            check("ws_idx", {grant_vld, grant_idx}, 128'b100);
        end
        cycle();
        check("ws_done_pready", s_pready, 128'b0001);
        check("ws_done_rdata", s_resp[0].rdata, 128'hDEADBEEF);
        drain(10);

        // Contention: ports 1, 2 and 3 request continuously from reset
        do_reset();
        ws = 0;
        resp_val = '{rdata: 32'h1234_5678, slverr: 1'b1};
        for (int t = 0; t < 2; t++) begin
            for (int p = 1; p < N; p++) push(p, mk_req(p, seq[p] + t), resp_val);
        end
        chk_gap = 1'b1;
        last_done = -1;
        for (int p = 1; p < N; p++) start_req(p, 2);
        drain(60);
        chk_gap = 1'b0;

        // Fairness wrap: pointer sits at 0 after serving port 3
        push(0, mk_req(0, seq[0]), resp_val);
        push(3, mk_req(3, seq[3]), resp_val);
        start_req(0, 1);
        start_req(3, 1);
        drain(30);

        // Withdraw: port 2 pulses psel during port 1's ACCESS and is never served
        ws = 3;
        push(1, mk_req(1, seq[1]), resp_val);
        start_req(1, 1);
        cycle();
        cycle();
        s_psel[2] = 1'b1;
        s_req[2] = mk_req(2, 99);
        cycle();
        cycle();
        s_psel[2] = 1'b0;
        drain(20);
        ws = 0;
        push(2, mk_req(2, seq[2]), resp_val);
        push(3, mk_req(3, seq[3]), resp_val);
        start_req(2, 1);
        start_req(3, 1);
        drain(30);

        // Reset while the downstream side stalls in ACCESS
        push(1, mk_req(1, seq[1]), resp_val);
        start_req(1, 1);
        drain(20);
        ws = 20;
        start_req(2, 1);
        cycle();
        cycle();
        cycle();
        check("stall_access", {m_penable, grant_idx}, 128'b110);
        #2;
        rst = 1'b1;
        #1;
        check_reset("mid_rst");
        s_psel = '0;
        s_penable = '0;
        for (int i = 0; i < N; i++) remaining[i] = 0;
        @(negedge clk);
        rst = 1'b0;
        ws = 0;
        push(1, mk_req(1, seq[1]), resp_val);
        push(3, mk_req(3, seq[3]), resp_val);
        start_req(1, 1);
        start_req(3, 1);
        drain(30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multisim_apb_arbiter.md
# multisim_apb_arbiter

Round-robin arbiter that shares one downstream APB subordinate path (typically a multisim APB push client toward a server) between `NUM_REQ` upstream APB requesters. Each upstream port behaves as an APB subordinate. The single downstream port behaves as an APB manager that replays the granted requester's transfer and routes the response back. Only one transfer is in flight at a time, and payloads are registered at grant so the downstream side sees stable signals.

## Interface
- `NUM_REQ`, default 2: number of upstream requesters, ≥1.
- `apb_req_t`, no default: APB request payload type (addr/write/wdata/strb…), opaque to this block.
- `apb_resp_t`, no default: APB response payload type (rdata/slverr…), opaque.
- `clk`  in  1: single clock.
- `rst`  in  1: asynchronous, active-high reset.
- `i_apb_s_req`  in  `NUM_REQ` x `apb_req_t`: upstream request payloads.
- `i_apb_s_psel`  in  `NUM_REQ`: upstream psel.
- `i_apb_s_penable`  in  `NUM_REQ`: upstream penable.
- `o_apb_s_pready`  out  `NUM_REQ`: upstream pready.
- `o_apb_s_resp`  out  `NUM_REQ` x `apb_resp_t`: upstream responses.
- `o_apb_m_req`  out  `apb_req_t`: downstream request payload (registered).
- `o_apb_m_psel`  out  1: downstream psel.
- `o_apb_m_penable`  out  1: downstream penable.
- `i_apb_m_pready`  in  1: downstream pready.
- `i_apb_m_resp`  in  `apb_resp_t`: downstream response.
- `o_grant_vld`  out  1: a transfer is in flight (state ≠ IDLE).
- `o_grant_idx`  out  `IW`: index of the granted requester. `IW` = max(1, $clog2(`NUM_REQ`)).

## Operation
- FSM states:
  - **IDLE**: no downstream transfer.
  - **SETUP**: `o_apb_m_psel`=1, `o_apb_m_penable`=0, exactly one cycle.
  - **ACCESS**: `o_apb_m_psel`=1, `o_apb_m_penable`=1, held until `i_apb_m_pready`.
- IDLE → SETUP when any `i_apb_s_psel[i]`=1. Winner = first asserted index searching from `rr_ptr` upward, wrapping modulo `NUM_REQ`. On this edge, register `grant_idx`=winner and `o_apb_m_req`=`i_apb_s_req[winner]`.
- SETUP → ACCESS unconditionally.
- ACCESS → IDLE when `i_apb_m_pready`=1. On this edge, `rr_ptr` ← (`grant_idx`+1) mod `NUM_REQ`.
- ACCESS with `i_apb_m_pready`=0: hold; payload and grant are unchanged.
- Response routing is combinational. In ACCESS, `o_apb_s_pready[grant_idx]`=`i_apb_m_pready` and `o_apb_s_resp[grant_idx]`=`i_apb_m_resp`. All other ports drive pready=0 and resp='0 at all times.
- `i_apb_s_penable` is not used for arbitration. A requester in its own ACCESS phase simply waits with pready low.
- Requester drops psel before being granted: it is not served, and no state remains.
- Requester drops psel after grant: this is a protocol violation. The downstream transfer still completes and the response is discarded; no hang.
- `NUM_REQ`=1: degenerates to a registered APB pass-through with the same timing.

## Timing
- Reset (async assert, sync deassert by the environment): state=IDLE, `rr_ptr`=0, `grant_idx`=0. Outputs: `o_apb_m_req`='0, `o_apb_m_psel`=0, `o_apb_m_penable`=0, `o_apb_s_pready`=0, `o_apb_s_resp`='0, `o_grant_vld`=0, `o_grant_idx`=0.
- Reset asserted mid-transfer: all outputs go to the reset values immediately. The pending upstream transfer is dropped without pready.
- Latency: requester psel seen in cycle T (state IDLE) → downstream SETUP in T+1 → ACCESS in T+2. With zero-wait downstream, upstream pready is high in T+2. Minimum upstream transfer = 3 cycles.
- Minimum gap: one IDLE cycle between consecutive downstream transfers, so the back-to-back throughput is one transfer per 3 cycles.
- psel rising on another port during SETUP/ACCESS is ignored until the next IDLE cycle.
- Simultaneous requests in IDLE: exactly one grant, chosen by `rr_ptr`. No requester waits more than `NUM_REQ`-1 foreign transfers.

## Test plan
- Single request: port 0 writes addr 0x10, downstream pready after 0 waits → m_psel high in T+1, penable in T+2, `o_apb_s_pready[0]`=1 in T+2, `o_apb_m_req` matches, port 1 pready stays 0.
- Wait states: downstream holds pready low for 4 ACCESS cycles, returning rdata 0xDEADBEEF → `o_apb_m_req`/`o_grant_idx` stable throughout, port 0 sees pready and 0xDEADBEEF only on the 5th ACCESS cycle.
- Contention (`NUM_REQ`=4): ports 1, 2 and 3 all request continuously from reset → grant order 1, 2, 3, 1, 2, 3, each transfer separated by exactly one IDLE cycle.
- Fairness wrap: after serving port 3, ports 0 and 3 both request → port 0 is granted first.
- Withdraw: port 2 raises psel during port 1's ACCESS and drops it before IDLE → port 2 is never granted and `rr_ptr` is unaffected.
- Reset mid-ACCESS: assert `rst` while downstream stalls → all outputs reach reset values in the same cycle. After release, the next request is granted starting from `rr_ptr`=0.
